// File: rtl/cache_axi_pkg.sv
// Types shared by the cache-line arbiter, the AXI bridge and both caches.
package cache_axi_pkg;

    localparam int LINE_WORDS = 8;

    typedef logic [LINE_WORDS-1:0][31:0] line_t;

    typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_e;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} arb_state_e;

    typedef enum logic {OP_RD = 1'b0, OP_WR = 1'b1} op_e;

    // A D-cache request asserting both read and write-back is treated as a write-back.
    function automatic op_e d_op(input logic wr_req);
        return wr_req ? OP_WR : OP_RD;
    endfunction

endpackage

// File: rtl/cache_axi_arbiter_rr_pick2.sv
// Two-way round-robin selector: on a tie, the requester not served last wins.
module rr_pick2
    import cache_axi_pkg::*;
(
    input  logic   i_req,
    input  logic   d_req,
    input  owner_e last_owner,
    output logic   valid,
    output owner_e pick
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        valid = i_req | d_req;
        pick  = OWN_I;
        if (i_req && d_req) begin
            pick = (last_owner == OWN_I) ? OWN_D : OWN_I;
        end else if (d_req) begin
            pick = OWN_D;
        end
    end

endmodule

// File: rtl/cache_axi_arbiter.sv
// Shares one cache-line AXI bridge between the I-cache (refill) and the D-cache (refill/write-back).
module cache_axi_arbiter #(
    parameter int LINE_WORDS = cache_axi_pkg::LINE_WORDS,
    parameter int ADDR_W     = 32
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        i_req,
    input  logic [ADDR_W-1:0]           i_addr,
    output logic                        i_gnt,
    output logic [LINE_WORDS-1:0][31:0] i_rd_line,
    input  logic                        d_rd_req,
    input  logic                        d_wr_req,
    input  logic [ADDR_W-1:0]           d_addr,
    input  logic [LINE_WORDS-1:0][31:0] d_wr_line,
    output logic                        d_gnt,
    output logic [LINE_WORDS-1:0][31:0] d_rd_line,
    input  logic                        m_gnt,
    output logic [ADDR_W-1:0]           m_addr,
    output logic                        m_rd_req,
    output logic                        m_wr_req,
    output logic [LINE_WORDS-1:0][31:0] m_wr_line,
    input  logic [LINE_WORDS-1:0][31:0] m_rd_line
);
    import cache_axi_pkg::*;

    typedef logic [LINE_WORDS-1:0][31:0] line_w_t;

    arb_state_e state;
    owner_e     owner;
    owner_e     last_owner;
    owner_e     pick;
    logic       pick_valid;
    op_e        grant_op;
    line_w_t    line_buf;

    rr_pick2 u_pick (
        .i_req      (i_req),
        .d_req      (d_rd_req | d_wr_req),
        .last_owner (last_owner),
        .valid      (pick_valid),
        .pick       (pick)
    );

    assign grant_op = (pick == OWN_D) ? d_op(d_wr_req) : OP_RD;

    // The bridge samples m_addr combinationally during its handshake, so every bridge-facing
    // output is a register loaded once at grant and held until m_gnt.
    always_ff @(posedge aclk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!aresetn) begin
            state      <= IDLE;
            owner      <= OWN_I;
            last_owner <= OWN_I;
            m_addr     <= '0;
            m_rd_req   <= 1'b0;
            m_wr_req   <= 1'b0;
            m_wr_line  <= '0;
            // NOTE: the line buffer drives both *_rd_line outputs, so it is reset to keep them 0.
            line_buf   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner     <= pick;
                        m_addr    <= (pick == OWN_D) ? d_addr : i_addr;
                        m_rd_req  <= (grant_op == OP_RD);
                        m_wr_req  <= (grant_op == OP_WR);
                        m_wr_line <= (grant_op == OP_WR) ? d_wr_line : '0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    // Drop the request on the completion edge: the bridge is idle next cycle.
                    if (m_gnt) begin
                        line_buf <= m_rd_line;
                        m_rd_req <= 1'b0;
                        m_wr_req <= 1'b0;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    last_owner <= owner;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign i_gnt     = (state == RESP) && (owner == OWN_I);
    assign d_gnt     = (state == RESP) && (owner == OWN_D);
    assign i_rd_line = line_buf;
    assign d_rd_line = line_buf;

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Directed self-checking bench for cache_axi_arbiter with a cycle-driven bridge model.
module tb_cache_axi_arbiter;
    import cache_axi_pkg::*;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    line_t       i_rd_line;
    logic        d_rd_req;
    logic        d_wr_req;
    logic [31:0] d_addr;
    line_t       d_wr_line;
    logic        d_gnt;
    line_t       d_rd_line;
    logic        m_gnt;
    logic [31:0] m_addr;
    logic        m_rd_req;
    logic        m_wr_req;
    line_t       m_wr_line;
    line_t       m_rd_line;

    int vectors     = 0;
    int miscompares = 0;

    always #5 aclk = ~aclk;

    cache_axi_arbiter dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_gnt     (i_gnt),
        .i_rd_line (i_rd_line),
        .d_rd_req  (d_rd_req),
        .d_wr_req  (d_wr_req),
        .d_addr    (d_addr),
        .d_wr_line (d_wr_line),
        .d_gnt     (d_gnt),
        .d_rd_line (d_rd_line),
        .m_gnt     (m_gnt),
        .m_addr    (m_addr),
        .m_rd_req  (m_rd_req),
        .m_wr_req  (m_wr_req),
        .m_wr_line (m_wr_line),
        .m_rd_line (m_rd_line)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick;
        @(posedge aclk);
        @(negedge aclk);
    endtask

    function automatic line_t make_line(input logic [31:0] base);
        line_t l;
        for (int k = 0; k < LINE_WORDS; k++) l[k] = base + 32'(k);
        return l;
    endfunction

    // Entered in an IDLE cycle with the request already presented; returns in the RESP cycle.
    task automatic bridge_serve(input string tag, input logic [31:0] exp_addr, input logic exp_wr,
                                input logic own_d, input line_t wl, input line_t rl, input int lat);
        tick;
        for (int c = 0; c <= lat; c++) begin
            vectors++;
            if (m_addr !== exp_addr || m_rd_req !== ~exp_wr || m_wr_req !== exp_wr ||
                i_gnt !== 1'b0 || d_gnt !== 1'b0) begin
                miscompares++;
                $display("FAIL %s busy c%0d: got addr=%h rd=%b wr=%b ig=%b dg=%b, want addr=%h rd=%b wr=%b ig=0 dg=0",
                         tag, c, m_addr, m_rd_req, m_wr_req, i_gnt, d_gnt, exp_addr, ~exp_wr, exp_wr);
            end
            if (exp_wr) begin
                vectors++;
                if (m_wr_line !== wl) begin
                    miscompares++;
                    $display("FAIL %s wr_line c%0d: got %h want %h", tag, c, m_wr_line, wl);
                end
            end
            if (c < lat) tick;
        end
        m_gnt     = 1'b1;
        m_rd_line = rl;
        tick;
        m_gnt     = 1'b0;
        m_rd_line = make_line(32'hDEAD_0000);
        vectors++;
        if (i_gnt !== ~own_d || d_gnt !== own_d || m_rd_req !== 1'b0 || m_wr_req !== 1'b0) begin
            miscompares++;
            $display("FAIL %s resp: got ig=%b dg=%b rd=%b wr=%b, want ig=%b dg=%b rd=0 wr=0",
                     tag, i_gnt, d_gnt, m_rd_req, m_wr_req, ~own_d, own_d);
        end
        if (!exp_wr) begin
            vectors++;
            if (i_rd_line !== rl || d_rd_line !== rl) begin
                miscompares++;
                $display("FAIL %s rd_line: got i=%h d=%h want %h", tag, i_rd_line, d_rd_line, rl);
            end
        end
    endtask

    task automatic test_reset;
        aresetn   = 1'b0;
        i_req     = 1'b1;
        i_addr    = 32'h1234_5670;
        d_rd_req  = 1'b0;
        d_wr_req  = 1'b0;
        d_addr    = '0;
        d_wr_line = '0;
        m_gnt     = 1'b0;
        m_rd_line = '0;
        tick;
        tick;
        vectors++;
        if ({m_rd_req, m_wr_req, i_gnt, d_gnt} !== 4'b0000 || m_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL reset ctl: got rd=%b wr=%b ig=%b dg=%b addr=%h, want all 0",
                     m_rd_req, m_wr_req, i_gnt, d_gnt, m_addr);
        end
        vectors++;
        if (m_wr_line !== '0 || i_rd_line !== '0 || d_rd_line !== '0) begin
            miscompares++;
            $display("FAIL reset lines: got wl=%h il=%h dl=%h, want 0", m_wr_line, i_rd_line, d_rd_line);
        end
        aresetn = 1'b1;
        bridge_serve("rst_release", 32'h1234_5670, 1'b0, 1'b0, '0, make_line(32'h55), 2);
        i_req = 1'b0;
        tick;
    endtask

    task automatic test_stray_gnt;
        m_gnt = 1'b1;
        tick;
        m_gnt = 1'b0;
        for (int c = 0; c < 2; c++) begin
            vectors++;
            if ({m_rd_req, m_wr_req, i_gnt, d_gnt} !== 4'b0000) begin
                miscompares++;
                $display("FAIL stray_gnt c%0d: got rd=%b wr=%b ig=%b dg=%b, want 0",
                         c, m_rd_req, m_wr_req, i_gnt, d_gnt);
            end
            tick;
        end
    endtask

    task automatic test_i_refill;
        i_addr = 32'h1FC0_0040;
        i_req  = 1'b1;
        bridge_serve("i_refill", 32'h1FC0_0040, 1'b0, 1'b0, '0, make_line(32'hA0), 3);
        i_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick;
            vectors++;
            if ({m_rd_req, m_wr_req, i_gnt, d_gnt} !== 4'b0000) begin
                miscompares++;
                $display("FAIL i_refill_after c%0d: got rd=%b wr=%b ig=%b dg=%b, want 0",
                         c, m_rd_req, m_wr_req, i_gnt, d_gnt);
            end
        end
    endtask

    // Each round: tie -> winner W, then loser L with no gap, then W again alone, so the next tie flips.
    task automatic test_tie_alternation;
        logic w_d;
        aresetn = 1'b0;
        tick;
        aresetn = 1'b1;
        i_addr  = 32'h0000_1100;
        d_addr  = 32'h0000_2200;
        for (int r = 0; r < 4; r++) begin
            w_d      = (r % 2 == 0);
            i_req    = 1'b1;
            d_rd_req = 1'b1;
            bridge_serve($sformatf("tie%0d_win", r), w_d ? 32'h0000_2200 : 32'h0000_1100,
                         1'b0, w_d, '0, make_line(32'h100 * (r + 1)), 1);
            if (w_d) d_rd_req = 1'b0; else i_req = 1'b0;
            tick;
            if (w_d) d_rd_req = 1'b1; else i_req = 1'b1;
            bridge_serve($sformatf("tie%0d_lose", r), w_d ? 32'h0000_1100 : 32'h0000_2200,
                         1'b0, ~w_d, '0, make_line(32'h1000 * (r + 1)), 1);
            if (w_d) i_req = 1'b0; else d_rd_req = 1'b0;
            tick;
            bridge_serve($sformatf("tie%0d_again", r), w_d ? 32'h0000_2200 : 32'h0000_1100,
                         1'b0, w_d, '0, make_line(32'h7000 + r), 1);
            if (w_d) d_rd_req = 1'b0; else i_req = 1'b0;
            tick;
        end
    endtask

    task automatic test_write_back;
        d_addr    = 32'h0000_1000;
        d_wr_line = make_line(32'h11);
        d_wr_req  = 1'b1;
        bridge_serve("write_back", 32'h0000_1000, 1'b1, 1'b1, make_line(32'h11), make_line(32'hE0), 4);
        d_wr_req = 1'b0;
        tick;
        vectors++;
        if (m_wr_req !== 1'b0 || d_gnt !== 1'b0) begin
            miscompares++;
            $display("FAIL wb_after: got wr=%b dg=%b, want 0 0", m_wr_req, d_gnt);
        end
    endtask

    task automatic test_rd_wr_both;
        d_addr    = 32'h0000_2000;
        d_wr_line = make_line(32'h21);
        d_rd_req  = 1'b1;
        d_wr_req  = 1'b1;
        tick;
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if (m_addr !== 32'h0000_2000 || m_wr_req !== 1'b1 || m_rd_req !== 1'b0 ||
                m_wr_line !== make_line(32'h21)) begin
                miscompares++;
                $display("FAIL rdwr busy c%0d: got addr=%h rd=%b wr=%b, want addr=00002000 rd=0 wr=1",
                         c, m_addr, m_rd_req, m_wr_req);
            end
            i_req  = 1'b1;
            i_addr = 32'h0000_5000 + 32'(c) * 32'h100;
            if (c < 2) tick;
        end
        m_gnt = 1'b1;
        tick;
        m_gnt = 1'b0;
        vectors++;
        if (d_gnt !== 1'b1 || i_gnt !== 1'b0 || m_wr_req !== 1'b0) begin
            miscompares++;
            $display("FAIL rdwr resp: got dg=%b ig=%b wr=%b, want dg=1 ig=0 wr=0", d_gnt, i_gnt, m_wr_req);
        end
        d_rd_req = 1'b0;
        d_wr_req = 1'b0;
        tick;
        bridge_serve("i_after_d", 32'h0000_5200, 1'b0, 1'b0, '0, make_line(32'hC0), 1);
        i_req = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid_busy;
        i_addr   = 32'h0000_3000;
        d_addr   = 32'h0000_4000;
        i_req    = 1'b1;
        d_rd_req = 1'b1;
        tick;
        vectors++;
        if (m_rd_req !== 1'b1 || m_addr !== 32'h0000_4000) begin
            miscompares++;
            $display("FAIL mid_rst busy: got rd=%b addr=%h, want rd=1 addr=00004000", m_rd_req, m_addr);
        end
        tick;
        tick;
        aresetn = 1'b0;
        m_gnt   = 1'b1;
        tick;
        m_gnt = 1'b0;
        for (int c = 0; c < 2; c++) begin
            vectors++;
            if ({m_rd_req, m_wr_req, i_gnt, d_gnt} !== 4'b0000 || m_addr !== 32'h0) begin
                miscompares++;
                $display("FAIL mid_rst c%0d: got rd=%b wr=%b ig=%b dg=%b addr=%h, want all 0",
                         c, m_rd_req, m_wr_req, i_gnt, d_gnt, m_addr);
            end
            if (c == 0) tick;
        end
        aresetn = 1'b1;
        bridge_serve("post_rst_d", 32'h0000_4000, 1'b0, 1'b1, '0, make_line(32'h400), 2);
        d_rd_req = 1'b0;
        tick;
        bridge_serve("post_rst_i", 32'h0000_3000, 1'b0, 1'b0, '0, make_line(32'h300), 2);
        i_req = 1'b0;
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stray_gnt();
        test_i_refill();
        test_tie_alternation();
        test_write_back();
        test_rd_wr_both();
        test_reset_mid_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
